// File: rtl/csr_ddr3_pkg.sv
// Shared definitions for the DDR3 CSR command requester.
// Register map, status bit layout and FSM state encoding.
package csr_ddr3_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TIMER  = 2'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_TOUT  = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_STRAY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/csr_ddr3_cmdreq.sv
// CSR-side command requester toward the DDR3 domain.
// Issues spaced request pulses, waits for ack, tracks sticky status.
module csr_ddr3_cmdreq
  import csr_ddr3_pkg::*;
#(
  parameter logic [3:0] CSR_ADDR = 4'h0,
  parameter int         TIMEOUT  = 1024,
  parameter int         GAP      = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        cmd_pulse,
  output logic [15:0] cmd_word,
  input  logic        ack_pulse,
  output logic        irq
);

  localparam int GW = $clog2(GAP);
  localparam logic [15:0]   T_LAST = 16'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

  state_t        state;
  logic [15:0]   timer;
  logic [GW-1:0] gap;
  logic          done;
  logic          tout;
  logic          ovr;
  logic          stray;

  logic          sel;
  logic [1:0]    idx;
  logic          wr_cmd;
  logic          wr_st;
  logic          start;
  logic          ev_done;
  logic          ev_tout;
  logic          ev_ovr;
  logic          ev_stray;
  logic [3:0]    clr;
  logic          busy;
  logic [4:0]    st;
  logic          unused;

  assign sel    = (csr_a[13:10] == CSR_ADDR);
  assign idx    = csr_a[1:0];
  assign wr_cmd = csr_we && sel && (idx == REG_CMD);
  assign wr_st  = csr_we && sel && (idx == REG_STATUS);
  assign busy   = (state != IDLE);

  assign start    = wr_cmd && (state == IDLE);
  assign ev_ovr   = wr_cmd && (state != IDLE);
  assign ev_done  = (state == WAIT) && ack_pulse;
  assign ev_tout  = (state == WAIT) && !ack_pulse
                 && (timer == T_LAST);
  assign ev_stray = ack_pulse && (state != WAIT);
  assign clr      = wr_st ? csr_di[4:1] : 4'b0;

  assign irq    = done | tout;
  assign unused = ^{csr_a[9:2], csr_di[31:16]};

  // Request sequencer: latch, single pulse, wait, spacing hold.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cmd_pulse <= 1'b0;
      cmd_word  <= 16'h0;
      timer     <= 16'h0;
      gap       <= '0;
    end else begin
      cmd_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cmd_word <= csr_di[15:0];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_pulse <= 1'b1;
          timer     <= 16'h0;
          state     <= WAIT;
        end
        WAIT: begin
          if (ev_done || ev_tout) begin
            gap   <= '0;
            state <= HOLD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        HOLD: begin
          if (gap == G_LAST) begin
            state <= IDLE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky status: events set, W1C clears, set wins on collision.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      done  <= 1'b0;
      tout  <= 1'b0;
      ovr   <= 1'b0;
      stray <= 1'b0;
    end else begin
      done  <= ev_done  | (done  & ~clr[0] & ~start);
      tout  <= ev_tout  | (tout  & ~clr[1] & ~start);
      ovr   <= ev_ovr   | (ovr   & ~clr[2]);
      stray <= ev_stray | (stray & ~clr[3]);
    end
  end

  // Assemble the STATUS register image.
  always_comb begin
    st           = '0;
    st[ST_BUSY]  = busy;
    st[ST_DONE]  = done;
    st[ST_TOUT]  = tout;
    st[ST_OVR]   = ovr;
    st[ST_STRAY] = stray;
  end

  // Registered read port, zero when the bank is not addressed.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_do <= 32'h0;
    end else if (!sel) begin
      csr_do <= 32'h0;
    end else begin
      case (idx)
        REG_CMD:    csr_do <= {16'h0, cmd_word};
        REG_STATUS: csr_do <= {27'h0, st};
        REG_TIMER:  csr_do <= {16'h0, timer};
        default:    csr_do <= 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ddr3_cmdreq.sv
// Bench for csr_ddr3_cmdreq: directed scenarios plus random traffic
// against a transaction-timestamp reference model.
module tb_csr_ddr3_cmdreq;

  localparam int TO = 16;
  localparam int GP = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        cmd_pulse;
  logic [15:0] cmd_word;
  logic        ack_pulse;
  logic        irq;

  int n_run = 0;
  int n_fail = 0;
  int dut_pulses = 0;

  always #5 sys_clk = ~sys_clk;

  csr_ddr3_cmdreq #(
    .CSR_ADDR(4'h0),
    .TIMEOUT (TO),
    .GAP     (GP)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .csr_a    (csr_a),
    .csr_we   (csr_we),
    .csr_di   (csr_di),
    .csr_do   (csr_do),
    .cmd_pulse(cmd_pulse),
    .cmd_word (cmd_word),
    .ack_pulse(ack_pulse),
    .irq      (irq)
  );

  // reference model: a transaction is described by its start edge,
  // its end edge (ack or expiry) and the GAP hold after it
  int          cyc = 0;
  bit          m_active, m_ended;
  int          m_s, m_e;
  logic [15:0] m_word, m_timer;
  bit          m_done, m_tout, m_ovr, m_stray, m_pulse;
  logic [31:0] m_do;

  function automatic logic [13:0] addr(input logic [3:0] b,
                                       input logic [1:0] i);
    return {b, 8'h00, i};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_ended = 0; m_s = 0; m_e = 0;
    m_word = 0; m_timer = 0; m_do = 0; m_pulse = 0;
    m_done = 0; m_tout = 0; m_ovr = 0; m_stray = 0;
  endfunction

  function automatic void model_edge();
    int e;
    bit idle, waiting, sel, wc, ws, start;
    bit sd, stt, so, ss;
    logic [1:0] idx;
    logic [3:0] clr;
    cyc++;
    e = cyc;
    idle = !m_active;
    waiting = m_active && !m_ended && (e - 1 >= m_s + 1);
    sel = (csr_a[13:10] == 4'h0);
    idx = csr_a[1:0];
    wc = csr_we && sel && (idx == 2'd0);
    ws = csr_we && sel && (idx == 2'd1);
    if (!sel) m_do = 0;
    else case (idx)
      2'd0: m_do = {16'h0, m_word};
      2'd1: m_do = {27'h0, m_stray, m_ovr, m_tout, m_done, !idle};
      2'd2: m_do = {16'h0, m_timer};
      default: m_do = 0;
    endcase
    sd = 0; stt = 0; so = 0; ss = 0; start = 0;
    clr = ws ? csr_di[4:1] : 4'h0;
    if (ack_pulse) begin
      if (waiting) sd = 1; else ss = 1;
    end else if (waiting && e == m_s + 1 + TO) begin
      stt = 1;
    end
    if (waiting && !sd && !stt) m_timer = 16'(e - (m_s + 1));
    if (sd || stt) begin m_ended = 1; m_e = e; end
    if (wc) begin
      if (idle) begin
        start = 1; m_active = 1; m_ended = 0; m_s = e;
        m_word = csr_di[15:0];
      end else so = 1;
    end
    if (m_active && e == m_s + 1) m_timer = 0;
    m_done  = sd  | (m_done  & !clr[0] & !start);
    m_tout  = stt | (m_tout  & !clr[1] & !start);
    m_ovr   = so  | (m_ovr   & !clr[2]);
    m_stray = ss  | (m_stray & !clr[3]);
    if (m_active && m_ended && e >= m_e + GP) m_active = 0;
    m_pulse = m_active && (e == m_s + 1);
  endfunction

  task automatic idle_inputs();
    csr_we = 0; ack_pulse = 0; csr_di = 0;
    csr_a = addr(4'h0, 2'd1);
  endtask

  task automatic clk_step();
    @(posedge sys_clk);
    model_edge();
    #1;
    if (cmd_pulse) dut_pulses++;
    idle_inputs();
  endtask

  task automatic do_reset();
    sys_rst = 1; idle_inputs(); model_reset();
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 0;
  endtask

  task automatic wr(input logic [1:0] i, input logic [31:0] d);
    csr_a = addr(4'h0, i); csr_we = 1; csr_di = d;
  endtask

  task automatic test_reset();
    sys_rst = 1; idle_inputs();
    #1;
    n_run++; if (cmd_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %0b exp 0", cmd_pulse); end
    n_run++; if (cmd_word !== 16'h0) begin n_fail++; $display("FAIL rst_word got %h exp 0000", cmd_word); end
    n_run++; if (csr_do !== 32'h0) begin n_fail++; $display("FAIL rst_do got %h exp 0", csr_do); end
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %0b exp 0", irq); end
    do_reset();
    clk_step();
    n_run++; if (csr_do !== 32'h0) begin n_fail++; $display("FAIL rst_status got %h exp 0", csr_do); end
  endtask

  task automatic test_issue();
    dut_pulses = 0;
    wr(2'd0, 32'hDEAD_00A5);
    clk_step();
    n_run++; if (cmd_pulse !== 1'b0) begin n_fail++; $display("FAIL issue_early got %0b exp 0", cmd_pulse); end
    n_run++; if (cmd_word !== 16'h00A5) begin n_fail++; $display("FAIL issue_word got %h exp 00a5", cmd_word); end
    clk_step();
    n_run++; if (cmd_pulse !== 1'b1) begin n_fail++; $display("FAIL issue_pulse got %0b exp 1", cmd_pulse); end
    n_run++; if (csr_do[0] !== 1'b1) begin n_fail++; $display("FAIL issue_busy got %0b exp 1", csr_do[0]); end
    clk_step();
    n_run++; if (cmd_pulse !== 1'b0) begin n_fail++; $display("FAIL issue_single got %0b exp 0", cmd_pulse); end
    n_run++; if (dut_pulses !== 1) begin n_fail++; $display("FAIL issue_count got %0d exp 1", dut_pulses); end
  endtask

  task automatic test_ack();
    repeat (8) clk_step();
    ack_pulse = 1;
    clk_step();
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ack_irq got %0b exp 1", irq); end
    for (int k = 1; k <= 5; k++) begin
      clk_step();
      n_run++; if (csr_do[0] !== (k <= GP)) begin n_fail++; $display("FAIL ack_gap_busy k=%0d got %0b exp %0b", k, csr_do[0], (k <= GP)); end
    end
    n_run++; if (csr_do !== 32'h2) begin n_fail++; $display("FAIL ack_status got %h exp 2", csr_do); end
    wr(2'd1, 32'h2);
    clk_step();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %0b exp 0", irq); end
    clk_step();
    n_run++; if (csr_do !== 32'h0) begin n_fail++; $display("FAIL w1c_status got %h exp 0", csr_do); end
  endtask

  task automatic test_timeout();
    do_reset();
    wr(2'd0, 32'h0BEE);
    clk_step();
    repeat (TO) clk_step();
    n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tout_early got %0b exp 0", irq); end
    clk_step();
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tout_irq got %0b exp 1", irq); end
    csr_a = addr(4'h0, 2'd2);
    clk_step();
    n_run++; if (csr_do !== 32'(TO - 1)) begin n_fail++; $display("FAIL tout_timer got %0d exp %0d", csr_do, TO - 1); end
    repeat (GP - 1) clk_step();
    n_run++; if (cmd_word !== 16'h0BEE) begin n_fail++; $display("FAIL tout_hold_word got %h exp 0bee", cmd_word); end
    ack_pulse = 1;
    clk_step();
    n_run++; if (csr_do !== 32'h4) begin n_fail++; $display("FAIL tout_idle_status got %h exp 4", csr_do); end
    clk_step();
    n_run++; if (csr_do !== 32'h14) begin n_fail++; $display("FAIL stray_status got %h exp 14", csr_do); end
  endtask

  task automatic test_ack_expiry();
    do_reset();
    wr(2'd0, 32'h0C0D);
    clk_step();
    repeat (TO) clk_step();
    ack_pulse = 1;
    clk_step();
    clk_step();
    n_run++; if (csr_do[2:0] !== 3'b011) begin n_fail++; $display("FAIL expiry_ack got %b exp 011", csr_do[2:0]); end
    n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL expiry_irq got %0b exp 1", irq); end
  endtask

  task automatic test_overrun();
    do_reset();
    dut_pulses = 0;
    wr(2'd0, 32'h0ABC);
    clk_step();
    repeat (3) clk_step();
    wr(2'd0, 32'h1234);
    clk_step();
    n_run++; if (cmd_word !== 16'h0ABC) begin n_fail++; $display("FAIL ovr_wait_word got %h exp 0abc", cmd_word); end
    ack_pulse = 1;
    clk_step();
    wr(2'd0, 32'h1234);
    clk_step();
    n_run++; if (cmd_word !== 16'h0ABC) begin n_fail++; $display("FAIL ovr_hold_word got %h exp 0abc", cmd_word); end
    n_run++; if (dut_pulses !== 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", dut_pulses); end
    clk_step();
    n_run++; if (csr_do[3:0] !== 4'b1011) begin n_fail++; $display("FAIL ovr_status got %b exp 1011", csr_do[3:0]); end
    repeat (2) clk_step();
    wr(2'd0, 32'h1234);
    clk_step();
    clk_step();
    n_run++; if (cmd_word !== 16'h1234) begin n_fail++; $display("FAIL ovr_next_word got %h exp 1234", cmd_word); end
    n_run++; if (dut_pulses !== 2) begin n_fail++; $display("FAIL ovr_next_pulses got %0d exp 2", dut_pulses); end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    wr(2'd0, 32'h0777);
    clk_step();
    repeat (4) clk_step();
    #2 sys_rst = 1;
    #1;
    n_run++; if (cmd_word !== 16'h0) begin n_fail++; $display("FAIL mid_rst_word got %h exp 0000", cmd_word); end
    n_run++; if ({cmd_pulse, irq, csr_do} !== 34'h0) begin n_fail++; $display("FAIL mid_rst_out got %0b %0b %h exp 0", cmd_pulse, irq, csr_do); end
    model_reset();
    @(posedge sys_clk);
    #1 sys_rst = 0;
    ack_pulse = 1;
    clk_step();
    clk_step();
    n_run++; if (csr_do !== 32'h10) begin n_fail++; $display("FAIL late_ack got %h exp 10", csr_do); end
    dut_pulses = 0;
    wr(2'd0, 32'h00A5);
    clk_step();
    clk_step();
    n_run++; if ({cmd_pulse, csr_do[0]} !== 2'b11) begin n_fail++; $display("FAIL rst_reissue got %b exp 11", {cmd_pulse, csr_do[0]}); end
    n_run++; if (cmd_word !== 16'h00A5) begin n_fail++; $display("FAIL rst_reissue_word got %h exp 00a5", cmd_word); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        wr(2'd0, $urandom);
      end else if (r < 12) begin
        wr(2'd1, $urandom);
      end else if (r < 15) begin
        csr_a = addr(4'h3, 2'($urandom_range(0, 3)));
        csr_we = 1; csr_di = $urandom;
      end else begin
        csr_a = addr(($urandom_range(0, 7) == 0) ? 4'h3 : 4'h0,
                     2'($urandom_range(0, 3)));
      end
      ack_pulse = ($urandom_range(0, 19) == 0);
      clk_step();
      n_run++; if (cmd_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse i=%0d got %0b exp %0b", i, cmd_pulse, m_pulse); end
      n_run++; if (cmd_word !== m_word) begin n_fail++; $display("FAIL rnd_word i=%0d got %h exp %h", i, cmd_word, m_word); end
      n_run++; if (irq !== (m_done | m_tout)) begin n_fail++; $display("FAIL rnd_irq i=%0d got %0b exp %0b", i, irq, m_done | m_tout); end
      n_run++; if (csr_do !== m_do) begin n_fail++; $display("FAIL rnd_do i=%0d got %h exp %h", i, csr_do, m_do); end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_issue();
    test_ack();
    test_timeout();
    test_ack_expiry();
    test_overrun();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
